data_memory_resp: RTL and testbench

- Word-addressed data memory that answers CPU load/store requests over a req/ack handshake with a fixed, parameterised access latency.
- Sits on the MEM stage's memory port, opposite the pipeline.
- Drives busy_o so the pipeline hazard logic can stall IF/ID and later stages while an access is in flight.
- Flags misaligned and out-of-range addresses instead of accessing memory.

---
 rtl/data_memory_resp_if.sv | 31 +++
 rtl/data_memory_resp.sv | 132 +++++++++++++
 tb/tb_data_memory_resp.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_resp_if.sv
// rtl/data_memory_resp_if.sv - load/store request/ack bus between the MEM stage and data memory
//
// Signals:
//   req_i    initiator -> memory  access request, held until ack_o
//   we_i     initiator -> memory  1 = store, 0 = load
//   addr_i   initiator -> memory  byte address
//   wdata_i  initiator -> memory  store data
//   ack_o    memory -> initiator  one-cycle completion pulse
//   rdata_o  memory -> initiator  load result, held until the next load completes
//   busy_o   memory -> initiator  access in flight (stall source)
//   err_o    memory -> initiator  qualifies ack_o, 1 = request rejected
interface data_memory_resp_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o, busy_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o, busy_o, err_o
  );
endinterface

// File: rtl/data_memory_resp.sv
// rtl/data_memory_resp.sv - word-addressed data memory with fixed-latency req/ack responses
//
// Ports:
//   clk_i  clock, all state changes on the rising edge
//   rst_i  synchronous active-high reset (memory contents are kept)
//   bus    data_memory_resp_if.slave: req/we/addr/wdata in, ack/rdata/busy/err out
//
// Parameters:
//   ADDR_W   word-address width, depth = 2**ADDR_W 32-bit words
//   LATENCY  edges from acceptance (counted as the first) to the ack cycle, 1..15
module data_memory_resp #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  data_memory_resp_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem_q [DEPTH];

  logic                addr_err;
  logic                done_entry;
  logic                mem_we;

  // Misaligned, or any bit above the word index set.
  assign addr_err = (bus.addr_i[1:0] != 2'b00) || (bus.addr_i[31:ADDR_W+2] != '0);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic; captured request fields come straight from the bus
  // on the acceptance edge so a LATENCY=1 access can complete on that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_i) begin
          we_d    = bus.we_i;
          idx_d   = bus.addr_i[ADDR_W+1:2];
          wdata_d = bus.wdata_i;
          err_d   = addr_err;
          if (addr_err || (LATENCY == 1)) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = 4'(LATENCY >= 2 ? LATENCY - 2 : 0);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The memory access happens on the edge that enters DONE, using the
  // captured (or just-captured) request; rejected requests never touch it.
  always_comb begin
    done_entry = (state_d == S_DONE) && (state_q != S_DONE);
    mem_we     = done_entry && !err_d && we_d;
    rdata_d    = rdata_q;
    if (done_entry && !err_d && !we_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  // No reset on the array; a reset edge suppresses a write on that edge.
  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  // Output decode.
  always_comb begin
    bus.ack_o   = (state_q == S_DONE);
    bus.err_o   = (state_q == S_DONE) && err_q;
    bus.busy_o  = (state_q != S_IDLE);
    bus.rdata_o = rdata_q;
  end

endmodule

// File: tb/tb_data_memory_resp.sv
// tb/tb_data_memory_resp.sv - self-checking bench for data_memory_resp
module tb_data_memory_resp;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_memory_resp_if bif0 ();
  data_memory_resp_if bif1 ();

  data_memory_resp #(.ADDR_W(10), .LATENCY(LAT)) u0 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif0)
  );

  data_memory_resp #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif1)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        drop;
    logic        keep;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [4:0]  lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];

  int total = 0;
  int bad   = 0;
  int accept_cyc = 0;
  int busy_cnt   = 0;
  int last_ack   = 0;
  int prev_ack   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic access(input vec_t v);
    exp_t e;
    int   n;
    logic got;
    n = 0;
    @(negedge clk);
    while (bif0.busy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    bif0.req_i   = 1'b1;
    bif0.we_i    = v.we;
    bif0.addr_i  = v.addr;
    bif0.wdata_i = v.wdata;
    e.err   = v.exp_err;
    e.rdata = v.exp_rdata;
    e.lat   = v.exp_err ? 5'd1 : 5'(LAT);
    sb.push_back(e);
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    busy_cnt   = 0;
    if (v.drop) begin
      bif0.req_i   = 1'b0;
      bif0.we_i    = ~v.we;
      bif0.addr_i  = ~v.addr;
      bif0.wdata_i = 32'h0;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bif0.busy_o) busy_cnt++;
      if (bif0.ack_o) got = 1'b1;
      else chk("err_without_ack", {31'd0, bif0.err_o}, 32'd0);
    end
    e = sb.pop_front();
    if (!got) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      prev_ack = last_ack;
      last_ack = cyc;
      chk("err_o", {31'd0, bif0.err_o}, {31'd0, e.err});
      chk("rdata_o", bif0.rdata_o, e.rdata);
      chk("latency", 32'(cyc - accept_cyc + 1), {27'd0, e.lat});
      chk("busy_cycles", 32'(busy_cnt), {27'd0, e.lat});
    end
    if (!v.keep) bif0.req_i = 1'b0;
  endtask

  initial begin
    //           we    addr          wdata         drop  keep  err   rdata
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'h0000_0001, 1'b0, 1'b1, 1'b0, 32'h0BAD_CAFE};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE};
    vecs[11] = '{1'b0, 32'h0000_0004, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0001};
    vecs[12] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0002};
    vecs[13] = '{1'b1, 32'h0000_0020, 32'h0000_0055, 1'b1, 1'b0, 1'b0, 32'h0000_0002};
    vecs[14] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0055};
    vecs[15] = '{1'b0, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0055};
    vecs[16] = '{1'b1, 32'h0000_0024, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0000_0055};
    vecs[17] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0BAD_CAFE};

    bif0.req_i = 1'b0; bif0.we_i = 1'b0; bif0.addr_i = 32'h0; bif0.wdata_i = 32'h0;
    bif1.req_i = 1'b0; bif1.we_i = 1'b0; bif1.addr_i = 32'h0; bif1.wdata_i = 32'h0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", {31'd0, bif0.ack_o}, 32'd0);
    chk("rst_err", {31'd0, bif0.err_o}, 32'd0);
    chk("rst_busy", {31'd0, bif0.busy_o}, 32'd0);
    chk("rst_rdata", bif0.rdata_o, 32'd0);

    for (int i = 0; i < 18; i++) begin
      access(vecs[i]);
      if (i > 0 && vecs[i-1].keep)
        chk("b2b_ack_spacing", 32'(last_ack - prev_ack), 32'(LAT + 1));
    end

    // Reset during the second WAIT cycle of a store to 0x24 (holds 0x11).
    @(negedge clk);
    bif0.req_i = 1'b1; bif0.we_i = 1'b1; bif0.addr_i = 32'h24; bif0.wdata_i = 32'hAA;
    @(posedge clk);
    #1 bif0.req_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("busy_before_rst", {31'd0, bif0.busy_o}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("busy_after_rst", {31'd0, bif0.busy_o}, 32'd0);
    chk("rdata_after_rst", bif0.rdata_o, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_ack_after_rst", {31'd0, bif0.ack_o}, 32'd0);
    end
    access('{1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 1'b0, 32'h11});

    // LATENCY=1 instance: store, load, errored load, each acked one edge after acceptance.
    @(negedge clk);
    bif1.req_i = 1'b1; bif1.we_i = 1'b1; bif1.addr_i = 32'h10; bif1.wdata_i = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    chk("l1_st_ack", {31'd0, bif1.ack_o}, 32'd1);
    chk("l1_st_err", {31'd0, bif1.err_o}, 32'd0);
    chk("l1_st_busy", {31'd0, bif1.busy_o}, 32'd1);
    bif1.req_i = 1'b0;
    @(negedge clk);
    chk("l1_idle_ack", {31'd0, bif1.ack_o}, 32'd0);
    chk("l1_idle_busy", {31'd0, bif1.busy_o}, 32'd0);
    bif1.req_i = 1'b1; bif1.we_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("l1_ld_ack", {31'd0, bif1.ack_o}, 32'd1);
    chk("l1_ld_rdata", bif1.rdata_o, 32'hDEAD_BEEF);
    bif1.req_i = 1'b0;
    @(negedge clk);
    bif1.req_i = 1'b1; bif1.addr_i = 32'h13;
    @(posedge clk);
    @(negedge clk);
    chk("l1_err_ack", {31'd0, bif1.ack_o}, 32'd1);
    chk("l1_err_err", {31'd0, bif1.err_o}, 32'd1);
    chk("l1_err_rdata", bif1.rdata_o, 32'hDEAD_BEEF);
    bif1.req_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
